// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcode
// constants and the WAIT timeout length.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWait   = 3'd4,
    StWb     = 3'd5,
    StDone   = 3'd6,
    StHalt   = 3'd7
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLoad = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpShl  = 4'h8;
  localparam logic [3:0] OpShr  = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  // Number of WAIT cycles tolerated without alu_ready before giving up.
  localparam logic [3:0] Timeout = 4'd15;

  // Opcodes that go through EXEC (NOP included, it just skips the datapath).
  function automatic logic is_exec_op(logic [3:0] op);
    return op <= OpShr;
  endfunction

endpackage

// File: rtl/cpu_sequencer_edge_detect.sv
// Single-bit rising-edge detector.
//   clock : system clock
//   reset : synchronous active-high reset, clears the previous-sample register
//   din   : level input
//   rise  : high while din=1 and the previous clocked sample was 0
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= din;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for a switch-driven datapath.
//   clock, reset : system clock, synchronous active-high reset
//   enabling     : run request, each 0->1 edge seen in IDLE starts one instruction
//   sw           : instruction word, opcode sw[7:4], immediate sw[3:0]
//   alu_ready    : datapath completion, only looked at in WAIT
//   ir_load      : strobe, instruction register load (FETCH)
//   alu_op, imm  : registered opcode / immediate
//   alu_start    : strobe, start datapath (EXEC, non-NOP)
//   acc_we       : strobe, accumulator write (WB)
//   disp_load    : strobe, display/result update (DONE)
//   busy, halted : status; err is sticky; icount counts retired instructions
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enabling,
  input  logic [7:0] sw,
  input  logic       alu_ready,
  output logic       ir_load,
  output logic [3:0] alu_op,
  output logic [3:0] imm,
  output logic       alu_start,
  output logic       acc_we,
  output logic       disp_load,
  output logic       busy,
  output logic       halted,
  output logic       err,
  output logic [7:0] icount
);

  logic       start;
  state_e     state_q, state_d;
  logic [3:0] alu_op_q, imm_q;
  logic       err_q, err_d;
  logic [7:0] icount_q;
  logic [3:0] tcnt_q, tcnt_d;

  edge_detect u_en_edge (
    .clock (clock),
    .reset (reset),
    .din   (enabling),
    .rise  (start)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    tcnt_d    = tcnt_q;
    ir_load   = 1'b0;
    alu_start = 1'b0;
    acc_we    = 1'b0;
    disp_load = 1'b0;
    busy      = 1'b1;
    halted    = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StFetch;
      end
      StFetch: begin
        ir_load = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (alu_op_q == OpHalt) begin
          state_d = StHalt;
        end else if (is_exec_op(alu_op_q)) begin
          state_d = StExec;
        end else begin
          // Illegal opcode retires as a NOP with the error flag raised.
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StExec: begin
        if (alu_op_q == OpNop) begin
          state_d = StDone;
        end else begin
          alu_start = 1'b1;
          tcnt_d    = 4'd0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (alu_ready) begin
          tcnt_d  = 4'd0;
          state_d = StWb;
        end else if (tcnt_q == Timeout - 4'd1) begin
          err_d   = 1'b1;
          tcnt_d  = 4'd0;
          state_d = StDone;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      StWb: begin
        acc_we  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        disp_load = 1'b1;
        state_d   = StIdle;
      end
      StHalt: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      alu_op_q <= 4'd0;
      imm_q    <= 4'd0;
      err_q    <= 1'b0;
      icount_q <= 8'd0;
      tcnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      if (state_q == StFetch) begin
        alu_op_q <= sw[7:4];
        imm_q    <= sw[3:0];
      end
      if (state_q == StDone) icount_q <= icount_q + 8'd1;
    end
  end

  assign alu_op = alu_op_q;
  assign imm    = imm_q;
  assign err    = err_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enabling = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       alu_ready = 1'b0;
  logic       ir_load, alu_start, acc_we, disp_load, busy, halted, err;
  logic [3:0] alu_op, imm;
  logic [7:0] icount;

  int checks = 0;
  int errors = 0;

  // Reference state: what the sequencer should be holding between instructions.
  logic       m_err;
  logic [7:0] m_icount;
  logic [3:0] m_op, m_imm;

  cpu_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .enabling  (enabling),
    .sw        (sw),
    .alu_ready (alu_ready),
    .ir_load   (ir_load),
    .alu_op    (alu_op),
    .imm       (imm),
    .alu_start (alu_start),
    .acc_we    (acc_we),
    .disp_load (disp_load),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .icount    (icount)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flags packed as {ir_load, alu_start, acc_we, disp_load, busy, halted, err}.
  function automatic logic [6:0] flags_now();
    return {ir_load, alu_start, acc_we, disp_load, busy, halted, err};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enabling = 1'b0; alu_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_err = 1'b0; m_icount = 8'd0; m_op = 4'd0; m_imm = 4'd0;
    check("reset flags", {25'd0, flags_now()}, 32'd0);
    check("reset alu_op", {28'd0, alu_op}, 32'd0);
    check("reset imm", {28'd0, imm}, 32'd0);
    check("reset icount", {24'd0, icount}, 32'd0);
  endtask

  // One instruction (never HALT). d = WAIT cycle (0-based) on which alu_ready rises;
  // d >= 15 means the datapath never answers. noisy randomises enabling, sw and
  // alu_ready wherever the sequencer must ignore them.
  task automatic run_instr(input logic [7:0] sw_v, input int d, input bit noisy);
    logic [3:0] op;
    int te, wb, as_c, err_c, wait_last;
    logic [6:0] exp_f;
    logic       e_err;
    op = sw_v[7:4];
    wb = -1; as_c = -1; err_c = -1; wait_last = -1;
    if (op >= 4'hA) begin
      te = 3; err_c = 3;
    end else if (op == 4'h0) begin
      te = 4;
    end else begin
      as_c = 3;
      wait_last = 4 + ((d < 15) ? d : 14);
      if (d < 15) begin
        wb = 5 + d; te = 6 + d;
      end else begin
        te = 19; err_c = 19;
      end
    end
    @(negedge clock);
    sw = sw_v; enabling = 1'b1;
    alu_ready = noisy ? 1'($urandom % 2) : 1'b0;
    for (int c = 1; c <= te + 1; c++) begin
      @(negedge clock);
      e_err = m_err | (err_c >= 0 && c >= err_c);
      exp_f = {c == 1, c == as_c, c == wb, c == te, c <= te, 1'b0, e_err};
      check($sformatf("flags sw=%02h c=%0d", sw_v, c), {25'd0, flags_now()}, {25'd0, exp_f});
      check($sformatf("alu_op c=%0d", c), {28'd0, alu_op}, {28'd0, (c >= 2) ? op : m_op});
      check($sformatf("imm c=%0d", c), {28'd0, imm},
            {28'd0, (c >= 2) ? sw_v[3:0] : m_imm});
      check($sformatf("icount c=%0d", c), {24'd0, icount},
            {24'd0, (c <= te) ? m_icount : m_icount + 8'd1});
      if (as_c >= 0 && c >= 4 && c <= wait_last) alu_ready = (c == 4 + d);
      else alu_ready = noisy ? 1'($urandom % 2) : 1'b0;
      if (c <= te) enabling = noisy ? 1'($urandom % 2) : 1'b1;
      else enabling = 1'b0;
      if (c >= 2 && noisy) sw = 8'($urandom);
    end
    m_op = op; m_imm = sw_v[3:0];
    m_err = m_err | (err_c >= 0);
    m_icount = m_icount + 8'd1;
  endtask

  task automatic run_halt();
    logic [6:0] exp_f;
    @(negedge clock);
    sw = 8'hF0; enabling = 1'b1; alu_ready = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      exp_f = {c == 1, 1'b0, 1'b0, 1'b0, c < 3, c >= 3, m_err};
      check($sformatf("halt flags c=%0d", c), {25'd0, flags_now()}, {25'd0, exp_f});
      check($sformatf("halt icount c=%0d", c), {24'd0, icount}, {24'd0, m_icount});
      enabling = (c == 4 || c == 6 || c == 8);
      alu_ready = 1'($urandom % 2);
      if (c >= 2) sw = 8'($urandom);
    end
    do_reset();
  endtask

  task automatic run_abort();
    int n_ir, n_dl;
    @(negedge clock);
    sw = 8'h25; enabling = 1'b1; alu_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 5) check("abort in WAIT busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1;
    @(negedge clock);
    check("abort flags", {25'd0, flags_now()}, 32'd0);
    check("abort alu_op", {28'd0, alu_op}, 32'd0);
    check("abort icount", {24'd0, icount}, 32'd0);
    reset = 1'b0;
    m_err = 1'b0; m_icount = 8'd0; m_op = 4'd0; m_imm = 4'd0;
    // Enabling now held high: exactly one instruction may run.
    enabling = 1'b1; alu_ready = 1'b1;
    n_ir = 0; n_dl = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_ir += int'(ir_load);
      n_dl += int'(disp_load);
    end
    check("held ir_load count", n_ir, 1);
    check("held disp_load count", n_dl, 1);
    check("held icount", {24'd0, icount}, 32'd1);
    check("held busy", {31'd0, busy}, 32'd0);
    enabling = 1'b0; alu_ready = 1'b0;
    m_icount = 8'd1; m_op = 4'h2; m_imm = 4'h5;
  endtask

  initial begin
    logic [7:0] s;
    int dly;
    do_reset();
    run_instr(8'h25, 0, 1'b0);
    do_reset();
    run_instr(8'h31, 15, 1'b0);
    do_reset();
    run_instr(8'hC0, 0, 1'b0);
    run_instr(8'h13, 2, 1'b0);
    run_instr(8'h07, 0, 1'b0);
    run_instr(8'h44, 14, 1'b0);
    do_reset();
    run_halt();
    run_abort();
    // Mixed random traffic including illegal opcodes and timeouts.
    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) do_reset();
      s = {4'($urandom_range(0, 14)), 4'($urandom)};
      dly = $urandom_range(0, 17);
      run_instr(s, dly, 1'b1);
    end
    // Long legal-only run so icount wraps past 0xFF with err staying clear.
    do_reset();
    for (int i = 0; i < 262; i++) begin
      s = {4'($urandom_range(0, 9)), 4'($urandom)};
      dly = $urandom_range(0, 14);
      run_instr(s, dly, 1'b1);
    end
    check("wrap icount", {24'd0, icount}, 32'd6);
    run_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
